// File: rtl/frl_ckpt_ctrl.sv
// frl_ckpt_ctrl: dispatch-side controller for the 16-entry free register list.
// Issues FRL pop strobes, stalls dispatch on an empty FRL or a full checkpoint
// buffer, and keeps a circular buffer of FRL head pointers, one per in-flight
// branch. A CDB flush reads the mispredicted branch's checkpoint back out
// combinationally, so the FRL can restore its head on the flush edge.
// Optional macro FRL_CKPT_STATS_EN adds saturating stall-statistics counters.
module frl_ckpt_ctrl #(
    parameter int CKPT_DEPTH = 4,
    parameter int CKPT_IDW   = 2,
    parameter int PTR_W      = 5
) (
    input  logic                Clk,
    input  logic                Resetb,
    input  logic                Dis_Valid,
    input  logic                Dis_RegWrite,
    input  logic                Dis_Branch,
    input  logic                Frl_Empty,
    input  logic [PTR_W-1:0]    Frl_HeadPtr,
    output logic                Dis_FrlRead,
    output logic                Ctl_Stall,
    output logic [CKPT_IDW-1:0] Ckpt_Id,
    output logic                Ckpt_Full,
    input  logic                Rob_BranchCommit,
    input  logic                Cdb_Flush,
    input  logic [CKPT_IDW-1:0] Cdb_FlushCkptId,
    output logic [PTR_W-1:0]    Cfc_FrlHeadPtr
`ifdef FRL_CKPT_STATS_EN
    ,
    output logic [15:0]         Stat_EmptyStalls,
    output logic [15:0]         Stat_FullStalls
`endif
);

    localparam logic [CKPT_IDW:0] FULL_CNT = (CKPT_IDW+1)'(CKPT_DEPTH);

    logic [PTR_W-1:0]    ckpt_mem [CKPT_DEPTH];
    logic [CKPT_IDW-1:0] head;
    logic [CKPT_IDW-1:0] tail;
    logic [CKPT_IDW:0]   count;
    logic [CKPT_IDW:0]   count_nxt;
    logic [CKPT_IDW-1:0] flush_dist;
    logic                push;
    logic                rel;

    // Dispatch handshake: a flush, an empty FRL for a register writer, or a
    // full buffer for a branch all hold the instruction at dispatch.
    assign Ckpt_Full      = (count == FULL_CNT);
    assign Ctl_Stall      = Dis_Valid & (Cdb_Flush | (Dis_RegWrite & Frl_Empty) |
                                         (Dis_Branch & Ckpt_Full));
    assign Dis_FrlRead    = Dis_Valid & Dis_RegWrite & ~Ctl_Stall;
    assign push           = Dis_Valid & Dis_Branch & ~Ctl_Stall;
    // A commit with no live checkpoint is ignored so the pointers never skew.
    assign rel            = Rob_BranchCommit & (count != '0);
    assign Ckpt_Id        = tail;
    assign Cfc_FrlHeadPtr = ckpt_mem[Cdb_FlushCkptId];
    assign flush_dist     = Cdb_FlushCkptId - head;

    // Next occupancy: a flush keeps entries head..flush id inclusive; otherwise
    // pushes and releases adjust the count (both together leave it unchanged).
    always_comb begin
        // NOTE: default first so every path assigns count_nxt and no latch is inferred.
        count_nxt = count;
        if (Cdb_Flush) begin
            count_nxt = {1'b0, flush_dist} + (CKPT_IDW+1)'(1) - (CKPT_IDW+1)'(rel);
        end else begin
            count_nxt = count + (CKPT_IDW+1)'(push) - (CKPT_IDW+1)'(rel);
        end
    end

    // Head/tail/count registers; a flush rewinds tail to just past the
    // mispredicted branch, discarding all younger checkpoints.
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            count <= count_nxt;
            if (rel) begin
                head <= head + CKPT_IDW'(1);
            end
            if (Cdb_Flush) begin
                tail <= Cdb_FlushCkptId + CKPT_IDW'(1);
            end else if (push) begin
                tail <= tail + CKPT_IDW'(1);
            end
        end
    end

    // Checkpoint storage: a pushing branch records the FRL head as it will be
    // after its own pop, so a branch-and-link keeps its destination register.
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            // NOTE: the buffer is small and is read combinationally on flush, so it is reset to a known value.
            for (int i = 0; i < CKPT_DEPTH; i++) begin
                ckpt_mem[i] <= '0;
            end
        end else if (push) begin
            ckpt_mem[tail] <= Frl_HeadPtr + PTR_W'(Dis_FrlRead);
        end
    end

`ifdef FRL_CKPT_STATS_EN
    // Saturating counters of cycles lost to an empty FRL or a full buffer,
    // excluding cycles already stalled by a flush.
    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            Stat_EmptyStalls <= '0;
            Stat_FullStalls  <= '0;
        end else begin
            if (Dis_Valid & Dis_RegWrite & Frl_Empty & ~Cdb_Flush &&
                Stat_EmptyStalls != 16'hFFFF) begin
                Stat_EmptyStalls <= Stat_EmptyStalls + 16'd1;
            end
            if (Dis_Valid & Dis_Branch & Ckpt_Full & ~Cdb_Flush &&
                Stat_FullStalls != 16'hFFFF) begin
                Stat_FullStalls <= Stat_FullStalls + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_frl_ckpt_ctrl.sv
// Directed self-checking bench for frl_ckpt_ctrl. Inputs change 1 ns after
// the rising edge; outputs are checked once settled, well before the next edge.
module tb_frl_ckpt_ctrl;

    logic       Clk = 1'b0;
    logic       Resetb;
    logic       Dis_Valid, Dis_RegWrite, Dis_Branch, Frl_Empty;
    logic [4:0] Frl_HeadPtr;
    logic       Dis_FrlRead, Ctl_Stall, Ckpt_Full;
    logic [1:0] Ckpt_Id;
    logic       Rob_BranchCommit, Cdb_Flush;
    logic [1:0] Cdb_FlushCkptId;
    logic [4:0] Cfc_FrlHeadPtr;
`ifdef FRL_CKPT_STATS_EN
    logic [15:0] Stat_EmptyStalls, Stat_FullStalls;
`endif

    int compared   = 0;
    int mismatched = 0;

    frl_ckpt_ctrl dut (
        .Clk              (Clk),
        .Resetb           (Resetb),
        .Dis_Valid        (Dis_Valid),
        .Dis_RegWrite     (Dis_RegWrite),
        .Dis_Branch       (Dis_Branch),
        .Frl_Empty        (Frl_Empty),
        .Frl_HeadPtr      (Frl_HeadPtr),
        .Dis_FrlRead      (Dis_FrlRead),
        .Ctl_Stall        (Ctl_Stall),
        .Ckpt_Id          (Ckpt_Id),
        .Ckpt_Full        (Ckpt_Full),
        .Rob_BranchCommit (Rob_BranchCommit),
        .Cdb_Flush        (Cdb_Flush),
        .Cdb_FlushCkptId  (Cdb_FlushCkptId),
        .Cfc_FrlHeadPtr   (Cfc_FrlHeadPtr)
`ifdef FRL_CKPT_STATS_EN
        ,
        .Stat_EmptyStalls (Stat_EmptyStalls),
        .Stat_FullStalls  (Stat_FullStalls)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    // Take the clock edge and return 1 ns after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Dis_Valid = 0; Dis_RegWrite = 0; Dis_Branch = 0; Frl_Empty = 0;
        Rob_BranchCommit = 0; Cdb_Flush = 0;
    endtask

    // Dispatch one branch (optionally also a register writer) and check its id.
    task automatic push_branch(input string tag, input logic [4:0] ptr,
                               input logic rw, input logic [1:0] exp_id);
        idle();
        Dis_Valid = 1; Dis_Branch = 1; Dis_RegWrite = rw; Frl_HeadPtr = ptr;
        settle();
        check({tag, "_stall"}, Ctl_Stall, 0);
        check({tag, "_id"}, Ckpt_Id, exp_id);
        tick();
        idle();
    endtask

    initial begin
        Resetb = 0; Frl_HeadPtr = 0; Cdb_FlushCkptId = 0;
        idle();
        #12;
        check("rst_full", Ckpt_Full, 0);
        check("rst_id", Ckpt_Id, 0);
        check("rst_cfc", Cfc_FrlHeadPtr, 0);
        check("rst_frlread", Dis_FrlRead, 0);
        check("rst_stall", Ctl_Stall, 0);
        @(negedge Clk);
        Resetb = 1;
        tick();

        // Register writers pop while the FRL has entries, stall when empty.
        Dis_Valid = 1; Dis_RegWrite = 1; Frl_Empty = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("pop_read", Dis_FrlRead, 1);
            check("pop_stall", Ctl_Stall, 0);
            tick();
        end
        Frl_Empty = 1;
        settle();
        check("empty_read", Dis_FrlRead, 0);
        check("empty_stall", Ctl_Stall, 1);
        Dis_Valid = 0;
        settle();
        check("novalid_stall", Ctl_Stall, 0);
        tick();
        idle();

        // Fill the buffer: mem = {2,5,7,9}.
        push_branch("p0", 5'd2, 0, 2'd0);
        push_branch("p1", 5'd5, 0, 2'd1);
        push_branch("p2", 5'd7, 0, 2'd2);
        push_branch("p3", 5'd9, 0, 2'd3);
        check("full_after4", Ckpt_Full, 1);
        Dis_Valid = 1; Dis_Branch = 1; Frl_HeadPtr = 5'd17;
        settle();
        check("p4_stall", Ctl_Stall, 1);
        check("p4_id", Ckpt_Id, 0);
        tick();
        idle();
        Cdb_FlushCkptId = 2'd2;
        settle();
        check("read_id2", Cfc_FrlHeadPtr, 7);
        Cdb_FlushCkptId = 2'd3;
        settle();
        check("read_id3_nopush", Cfc_FrlHeadPtr, 9);

        // Flush id 1 with head 0: keep ids 0,1 -> count 2, tail 2.
        Cdb_Flush = 1; Cdb_FlushCkptId = 2'd1;
        Dis_Valid = 1; Dis_RegWrite = 1; Frl_Empty = 0;
        settle();
        check("fl1_cfc", Cfc_FrlHeadPtr, 5);
        check("fl1_stall", Ctl_Stall, 1);
        check("fl1_read", Dis_FrlRead, 0);
        tick();
        idle();
        check("fl1_full", Ckpt_Full, 0);
        check("fl1_id", Ckpt_Id, 2);
        // Two more pushes refill it (count was 2); the second wraps 31+1 -> 0.
        push_branch("p5", 5'd20, 0, 2'd2);
        check("p5_full", Ckpt_Full, 0);
        Dis_Valid = 1; Dis_Branch = 1; Dis_RegWrite = 1; Frl_HeadPtr = 5'd31;
        settle();
        check("p6_read", Dis_FrlRead, 1);
        check("p6_id", Ckpt_Id, 3);
        tick();
        idle();
        check("p6_full", Ckpt_Full, 1);
        Cdb_FlushCkptId = 2'd2;
        settle();
        check("read_id2_new", Cfc_FrlHeadPtr, 20);

        // Full: commit plus branch in one cycle -> stalled; succeeds next cycle.
        Rob_BranchCommit = 1; Dis_Valid = 1; Dis_Branch = 1; Frl_HeadPtr = 5'd12;
        settle();
        check("cmt_push_stall", Ctl_Stall, 1);
        tick();
        idle();
        check("cmt_full", Ckpt_Full, 0);
        push_branch("p7", 5'd12, 0, 2'd0);
        check("p7_full", Ckpt_Full, 1);
        Cdb_FlushCkptId = 2'd0;
        settle();
        check("read_id0", Cfc_FrlHeadPtr, 12);

        // Flush of the wrapped checkpoint (id 3, head 1) restores pointer 0.
        Cdb_Flush = 1; Cdb_FlushCkptId = 2'd3;
        settle();
        check("fl3_cfc", Cfc_FrlHeadPtr, 0);
        tick();
        idle();
        check("fl3_full", Ckpt_Full, 0);
        check("fl3_id", Ckpt_Id, 0);
        push_branch("p8", 5'd8, 0, 2'd0);
        check("p8_full", Ckpt_Full, 1);

        // Asynchronous reset mid-cycle empties everything immediately.
        #2;
        Resetb = 0;
        Cdb_FlushCkptId = 2'd1;
        settle();
        check("arst_full", Ckpt_Full, 0);
        check("arst_id", Ckpt_Id, 0);
        check("arst_cfc", Cfc_FrlHeadPtr, 0);
        @(negedge Clk);
        Resetb = 1;
        tick();

        // Commit on an empty buffer is ignored; then refill with {10,11,12,13}.
        Rob_BranchCommit = 1;
        tick();
        idle();
        check("cmt_empty_id", Ckpt_Id, 0);
        push_branch("q0", 5'd10, 0, 2'd0);
        push_branch("q1", 5'd11, 0, 2'd1);
        push_branch("q2", 5'd12, 0, 2'd2);
        check("q2_full", Ckpt_Full, 0);
        push_branch("q3", 5'd13, 0, 2'd3);
        check("q3_full", Ckpt_Full, 1);

        // Flush id 2 with a commit (head 0): head 1, tail 3, count 2.
        Cdb_Flush = 1; Cdb_FlushCkptId = 2'd2; Rob_BranchCommit = 1;
        Dis_Valid = 1; Dis_RegWrite = 1; Frl_Empty = 0;
        settle();
        check("flc_cfc", Cfc_FrlHeadPtr, 12);
        check("flc_stall", Ctl_Stall, 1);
        check("flc_read", Dis_FrlRead, 0);
        tick();
        idle();
        check("flc_id", Ckpt_Id, 3);
        check("flc_full", Ckpt_Full, 0);
        push_branch("r0", 5'd14, 0, 2'd3);
        check("r0_full", Ckpt_Full, 0);
        push_branch("r1", 5'd15, 0, 2'd0);
        check("r1_full", Ckpt_Full, 1);
        // head must be 1: flush id 3 keeps ids 1..3 -> count 3, not full.
        Cdb_Flush = 1; Cdb_FlushCkptId = 2'd3;
        settle();
        check("fl_h1_cfc", Cfc_FrlHeadPtr, 14);
        tick();
        idle();
        check("fl_h1_full", Ckpt_Full, 0);
        check("fl_h1_id", Ckpt_Id, 0);
        push_branch("r2", 5'd16, 0, 2'd0);
        check("r2_full", Ckpt_Full, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
